uart_rx_ext: RTL and testbench

Parametrised UART receiver: the successor to the fixed 8N1 receiver inside `uart_top`. It adds a configurable frame format (5–9 data bits, none/even/odd parity, 1 or 2 stop bits), 3-sample majority voting and false-start rejection. It flags parity, framing, break and overrun errors, and returns data through a one-entry holding register with a valid/ready handshake. It runs on the shared `baud_gen` oversampling tick and feeds the APB register block.

---
 rtl/uart_pkg.sv | 42 ++++
 rtl/uart_rx_sampler.sv | 71 +++++++
 rtl/uart_rx_ext.sv | 192 +++++++++++++++++++
 tb/tb_uart_rx_ext.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and the matching transmitter.
//   PAR_*           parity mode encoding (none / even / odd)
//   OVERSAMPLE_DEF  default number of baud_gen ticks per bit
//   rx_state_e      receiver FSM states
//   rx_status_t     per-word error flags carried with the received data
//   parity_calc     expected parity bit for the low nbits of a word
package uart_pkg;

  localparam int unsigned PAR_NONE       = 0;
  localparam int unsigned PAR_EVEN       = 1;
  localparam int unsigned PAR_ODD        = 2;
  localparam int unsigned OVERSAMPLE_DEF = 16;
  localparam int unsigned MAX_DATA_BITS  = 9;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_DATA     = 3'd2,
    ST_PARITY   = 3'd3,
    ST_STOP     = 3'd4,
    ST_BRK_WAIT = 3'd5
  } rx_state_e;

  typedef struct packed {
    logic par_err;
    logic frm_err;
    logic brk;
  } rx_status_t;

  // Even parity is the XOR of the data bits; odd parity is its inverse.
  function automatic logic parity_calc(input logic [MAX_DATA_BITS-1:0] data,
                                       input int unsigned nbits,
                                       input int unsigned par);
    logic p;
    p = 1'b0;
    for (int i = 0; i < MAX_DATA_BITS; i++) begin
      if (i < int'(nbits)) p = p ^ data[i];
    end
    return (par == PAR_ODD) ? ~p : p;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: 2-FF synchroniser, per-bit tick counter and 3-sample majority voter.
//   clk, rst    clock, synchronous active-high reset
//   s_tick      oversampling tick
//   rx          raw serial line
//   tick_clr    holds the tick counter at 0 (receiver idle)
//   rx_sync     synchronised line
//   bit_val     majority of the three mid-bit samples
//   bit_strobe  combinational pulse on the s_tick of the mid-bit vote
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic s_tick,
  input  logic rx,
  input  logic tick_clr,
  output logic rx_sync,
  output logic bit_val,
  output logic bit_strobe
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] T_S0   = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_S1   = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] T_VOTE = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);

  logic          sync1_q, sync1_d, sync2_q, sync2_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          s0_q, s0_d, s1_q, s1_d;

  // Next-state: synchroniser shift, tick counter, first two vote samples.
  always_comb begin
    sync1_d = rx;
    sync2_d = sync1_q;
    tick_d  = tick_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    if (tick_clr) begin
      tick_d = '0;
    end else if (s_tick) begin
      tick_d = (tick_q == T_LAST) ? '0 : tick_q + TW'(1);
      if (tick_q == T_S0) s0_d = sync2_q;
      if (tick_q == T_S1) s1_d = sync2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      tick_q  <= '0;
      s0_q    <= 1'b1;
      s1_q    <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      tick_q  <= tick_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
    end
  end

  // Third sample is the live synchronised line on the vote tick.
  assign rx_sync    = sync2_q;
  assign bit_val    = (s0_q & s1_q) | (s0_q & sync2_q) | (s1_q & sync2_q);
  assign bit_strobe = s_tick && !tick_clr && (tick_q == T_VOTE);

endmodule

// File: rtl/uart_rx_ext.sv
// uart_rx_ext: configurable UART receiver with majority voting, error flags and
// a one-entry holding register.
//   clk, rst            clock, synchronous active-high reset
//   s_tick, en, rx      oversampling tick, receiver enable, serial line
//   rx_data/rx_valid    holding register, accepted when rx_valid && rx_ready
//   parity_err, frame_err, break_det  flags qualifying rx_data
//   overrun             one-cycle pulse when a completed frame is dropped
//   busy                FSM not idle
module uart_rx_ext
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = PAR_NONE,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_tick,
  input  logic                 en,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned BW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] B_LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] B_LAST_STOP = BW'(STOP_BITS - 1);

  rx_state_e            state_q, state_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 pbit_q, pbit_d;
  logic                 perr_pend_q, perr_pend_d;
  logic                 ferr_pend_q, ferr_pend_d;

  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  rx_status_t           stat_q, stat_d;
  logic                 overrun_q, overrun_d;
  logic                 busy_q, busy_d;

  logic                 rx_sync, bit_val, bit_strobe, tick_clr;
  logic                 done_c;
  rx_status_t           done_stat;

  assign tick_clr = (state_q == ST_IDLE);

  uart_rx_sampler #(.OVERSAMPLE(OVERSAMPLE)) u_sampler (
    .clk        (clk),
    .rst        (rst),
    .s_tick     (s_tick),
    .rx         (rx),
    .tick_clr   (tick_clr),
    .rx_sync    (rx_sync),
    .bit_val    (bit_val),
    .bit_strobe (bit_strobe)
  );

  // Frame FSM: all progress is paced by bit_strobe (mid-bit vote).
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    pbit_d      = pbit_q;
    perr_pend_d = perr_pend_q;
    ferr_pend_d = ferr_pend_q;
    done_c      = 1'b0;
    done_stat   = '0;
    case (state_q)
      ST_IDLE: begin
        bit_cnt_d   = '0;
        pbit_d      = 1'b0;
        perr_pend_d = 1'b0;
        ferr_pend_d = 1'b0;
        if (en && !rx_sync) state_d = ST_START;
      end
      ST_START: begin
        if (bit_strobe) state_d = bit_val ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (bit_strobe) begin
          shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == B_LAST_DATA) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_strobe) begin
          pbit_d      = bit_val;
          perr_pend_d = bit_val != parity_calc(MAX_DATA_BITS'(shift_q), DATA_BITS, PARITY);
          state_d     = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_strobe) begin
          // Break: an all-zero frame through the first stop bit.
          if ((bit_cnt_q == '0) && (shift_q == '0) &&
              ((PARITY == PAR_NONE) || !pbit_q) && !bit_val) begin
            done_c            = 1'b1;
            done_stat.frm_err = 1'b1;
            done_stat.brk     = 1'b1;
            state_d           = ST_BRK_WAIT;
          end else if (bit_cnt_q == B_LAST_STOP) begin
            done_c            = 1'b1;
            done_stat.par_err = perr_pend_q;
            done_stat.frm_err = ferr_pend_q | !bit_val;
            state_d           = ST_IDLE;
          end else begin
            ferr_pend_d = ferr_pend_q | !bit_val;
            bit_cnt_d   = bit_cnt_q + BW'(1);
          end
        end
      end
      ST_BRK_WAIT: begin
        if (s_tick && rx_sync) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Disable abandons any partial frame.
    if (!en) begin
      state_d = ST_IDLE;
      done_c  = 1'b0;
    end
  end

  // Holding register: load on completion if empty or being read, else overrun.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    stat_d     = stat_q;
    overrun_d  = 1'b0;
    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
    if (done_c) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        stat_d     = done_stat;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      pbit_q      <= 1'b0;
      perr_pend_q <= 1'b0;
      ferr_pend_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      stat_q      <= '0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      pbit_q      <= pbit_d;
      perr_pend_q <= perr_pend_d;
      ferr_pend_q <= ferr_pend_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      stat_q      <= stat_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = stat_q.par_err;
  assign frame_err  = stat_q.frm_err;
  assign break_det  = stat_q.brk;
  assign overrun    = overrun_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_ext.sv
// tb_uart_rx_ext: scoreboard bench for uart_rx_ext, one 8N1 and one 8E1 instance.
module tb_uart_rx_ext;

  localparam int BITCLK = 64;  // s_tick every 4 clk, 16 ticks per bit

  logic clk = 1'b0, rst = 1'b1, s_tick = 1'b0, en = 1'b1;
  logic [1:0] tdiv = 2'd0;
  logic rx_n = 1'b1, rx_e = 1'b1, ready_n = 1'b1, ready_e = 1'b1;
  logic [7:0] data_n, data_e;
  logic valid_n, valid_e, perr_n, perr_e, ferr_n, ferr_e;
  logic brk_n, brk_e, ovr_n, ovr_e, busy_n, busy_e;

  int total = 0;
  int bad   = 0;
  // Words are {break, frame_err, parity_err, data}.
  logic [10:0] obs_n[$];
  logic [10:0] obs_e[$];
  logic [10:0] exp_q[$];
  int rd_n = 0, rd_e = 0;
  int vcnt_n = 0, ocnt_n = 0, bcnt_n = 0;

  uart_rx_ext #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(16)) u_n (
    .clk(clk), .rst(rst), .s_tick(s_tick), .en(en), .rx(rx_n),
    .rx_data(data_n), .rx_valid(valid_n), .rx_ready(ready_n),
    .parity_err(perr_n), .frame_err(ferr_n), .break_det(brk_n),
    .overrun(ovr_n), .busy(busy_n)
  );

  uart_rx_ext #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .OVERSAMPLE(16)) u_e (
    .clk(clk), .rst(rst), .s_tick(s_tick), .en(en), .rx(rx_e),
    .rx_data(data_e), .rx_valid(valid_e), .rx_ready(ready_e),
    .parity_err(perr_e), .frame_err(ferr_e), .break_det(brk_e),
    .overrun(ovr_e), .busy(busy_e)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    tdiv   <= tdiv + 2'd1;
    s_tick <= (tdiv == 2'd3);
  end

  // Monitor: capture every accepted word and count activity cycles.
  always @(negedge clk) begin
    if (valid_n && ready_n) obs_n.push_back({brk_n, ferr_n, perr_n, data_n});
    if (valid_e && ready_e) obs_e.push_back({brk_e, ferr_e, perr_e, data_e});
    if (valid_n) vcnt_n++;
    if (ovr_n)   ocnt_n++;
    if (busy_n)  bcnt_n++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input bit sel, input logic v);
    if (sel) rx_e = v;
    else     rx_n = v;
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input bit has_par,
                            input logic pbit, input logic stop_v);
    set_rx(sel, 1'b0); step(BITCLK);
    for (int i = 0; i < 8; i++) begin
      set_rx(sel, d[i]); step(BITCLK);
    end
    if (has_par) begin
      set_rx(sel, pbit); step(BITCLK);
    end
    set_rx(sel, stop_v); step(BITCLK);
    set_rx(sel, 1'b1);   step(BITCLK);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(5);
    total++;
    if ({data_n, valid_n, perr_n, ferr_n, brk_n, ovr_n, busy_n} !== 14'h0) begin
      bad++;
      $display("FAIL reset_n: got %h want 0", {data_n, valid_n, perr_n, ferr_n, brk_n, ovr_n, busy_n});
    end
    total++;
    if ({data_e, valid_e, perr_e, ferr_e, brk_e, ovr_e, busy_e} !== 14'h0) begin
      bad++;
      $display("FAIL reset_e: got %h want 0", {data_e, valid_e, perr_e, ferr_e, brk_e, ovr_e, busy_e});
    end
    rst = 1'b0;
    step(4);
  endtask

  task automatic test_clean();
    int v0;
    logic [10:0] o, e;
    v0 = vcnt_n;
    exp_q.push_back({3'b000, 8'h55}); send_frame(0, 8'h55, 0, 1'b0, 1'b1);
    exp_q.push_back({3'b000, 8'hF1}); send_frame(0, 8'hF1, 0, 1'b0, 1'b1);
    for (int i = 0; i < 4 * BITCLK && (obs_n.size() - rd_n) < 2; i++) step(1);
    total++;
    if ((obs_n.size() - rd_n) != 2) begin
      bad++;
      $display("FAIL clean_count: got %0d want 2", obs_n.size() - rd_n);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (rd_n < obs_n.size()) ? obs_n[rd_n] : 11'bx;
      rd_n++;
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL clean_word: got %h want %h", o, e);
      end
    end
    total++;
    if (vcnt_n - v0 != 2) begin
      bad++;
      $display("FAIL clean_valid_cycles: got %0d want 2", vcnt_n - v0);
    end
  endtask

  task automatic test_parity();
    logic [7:0] d;
    logic pe;
    logic [10:0] o, e;
    d  = 8'hA3;
    pe = ^d;
    exp_q.push_back({3'b001, d}); send_frame(1, d, 1, ~pe, 1'b1);
    exp_q.push_back({3'b000, d}); send_frame(1, d, 1, pe, 1'b1);
    for (int i = 0; i < 4 * BITCLK && (obs_e.size() - rd_e) < 2; i++) step(1);
    total++;
    if ((obs_e.size() - rd_e) != 2) begin
      bad++;
      $display("FAIL parity_count: got %0d want 2", obs_e.size() - rd_e);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (rd_e < obs_e.size()) ? obs_e[rd_e] : 11'bx;
      rd_e++;
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL parity_word: got %h want %h", o, e);
      end
    end
  endtask

  task automatic test_bad_stop();
    logic [10:0] o, e;
    exp_q.push_back({3'b010, 8'hC7}); send_frame(0, 8'hC7, 0, 1'b0, 1'b0);
    step(2 * BITCLK);
    total++;
    if ((obs_n.size() - rd_n) != 1) begin
      bad++;
      $display("FAIL badstop_count: got %0d want 1", obs_n.size() - rd_n);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (rd_n < obs_n.size()) ? obs_n[rd_n] : 11'bx;
      rd_n++;
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL badstop_word: got %h want %h", o, e);
      end
    end
  endtask

  task automatic test_break();
    logic [10:0] o, e;
    exp_q.push_back({3'b110, 8'h00});
    set_rx(0, 1'b0); step(20 * BITCLK);
    set_rx(0, 1'b1); step(3 * BITCLK);
    total++;
    if ((obs_n.size() - rd_n) != 1) begin
      bad++;
      $display("FAIL break_count: got %0d want 1", obs_n.size() - rd_n);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (rd_n < obs_n.size()) ? obs_n[rd_n] : 11'bx;
      rd_n++;
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL break_word: got %h want %h", o, e);
      end
    end
  endtask

  task automatic test_glitch();
    int b0, n0;
    b0 = bcnt_n;
    n0 = obs_n.size();
    set_rx(0, 1'b0); step(16);
    set_rx(0, 1'b1); step(3 * BITCLK);
    total++;
    if (bcnt_n == b0) begin
      bad++;
      $display("FAIL glitch_busy_pulse: got 0 busy cycles want >0");
    end
    total++;
    if (obs_n.size() != n0) begin
      bad++;
      $display("FAIL glitch_no_word: got %0d words want 0", obs_n.size() - n0);
    end
    total++;
    if (busy_n !== 1'b0) begin
      bad++;
      $display("FAIL glitch_idle: got busy=%b want 0", busy_n);
    end
  endtask

  task automatic test_overrun();
    int o0;
    logic [10:0] o, e;
    ready_n = 1'b0;
    o0 = ocnt_n;
    send_frame(0, 8'h3C, 0, 1'b0, 1'b1);
    send_frame(0, 8'h5A, 0, 1'b0, 1'b1);
    step(BITCLK);
    total++;
    if ({valid_n, data_n} !== {1'b1, 8'h3C}) begin
      bad++;
      $display("FAIL ovr_hold: got valid=%b data=%h want 1 3c", valid_n, data_n);
    end
    total++;
    if (ocnt_n - o0 != 1) begin
      bad++;
      $display("FAIL ovr_pulse: got %0d cycles want 1", ocnt_n - o0);
    end
    total++;
    if (obs_n.size() != rd_n) begin
      bad++;
      $display("FAIL ovr_no_accept: got %0d words want 0", obs_n.size() - rd_n);
    end
    exp_q.push_back({3'b000, 8'h3C});
    ready_n = 1'b1;
    step(1);
    step(1);
    total++;
    if (valid_n !== 1'b0) begin
      bad++;
      $display("FAIL ovr_valid_clear: got %b want 0", valid_n);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (rd_n < obs_n.size()) ? obs_n[rd_n] : 11'bx;
      rd_n++;
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL ovr_word: got %h want %h", o, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    logic [10:0] o, e;
    d = 8'h96;
    ready_n = 1'b0;
    send_frame(0, 8'h12, 0, 1'b0, 1'b1);
    set_rx(0, 1'b0); step(BITCLK);
    for (int i = 0; i < 3; i++) begin
      set_rx(0, d[i]); step(BITCLK);
    end
    set_rx(0, d[3]); step(BITCLK / 2);
    rst = 1'b1;
    step(1);
    total++;
    if ({data_n, valid_n, perr_n, ferr_n, brk_n, ovr_n, busy_n} !== 14'h0) begin
      bad++;
      $display("FAIL rstmid_outputs: got %h want 0", {data_n, valid_n, perr_n, ferr_n, brk_n, ovr_n, busy_n});
    end
    rst = 1'b0;
    set_rx(0, 1'b1);
    ready_n = 1'b1;
    step(2 * BITCLK);
    rd_n = obs_n.size();
    exp_q.push_back({3'b000, d}); send_frame(0, d, 0, 1'b0, 1'b1);
    for (int i = 0; i < 4 * BITCLK && (obs_n.size() - rd_n) < 1; i++) step(1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (rd_n < obs_n.size()) ? obs_n[rd_n] : 11'bx;
      rd_n++;
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL rstmid_word: got %h want %h", o, e);
      end
    end
  endtask

  task automatic test_enable();
    int n0, v0;
    n0 = obs_n.size();
    v0 = vcnt_n;
    set_rx(0, 1'b0); step(BITCLK);
    for (int i = 0; i < 3; i++) begin
      set_rx(0, 1'b1); step(BITCLK);
    end
    step(BITCLK / 2);
    en = 1'b0;
    step(1);
    total++;
    if (busy_n !== 1'b0) begin
      bad++;
      $display("FAIL en_busy: got %b want 0", busy_n);
    end
    set_rx(0, 1'b1);
    step(2 * BITCLK);
    en = 1'b1;
    step(8 * BITCLK);
    total++;
    if ((obs_n.size() != n0) || (vcnt_n != v0)) begin
      bad++;
      $display("FAIL en_no_word: got %0d words %0d valid cycles want 0 0",
               obs_n.size() - n0, vcnt_n - v0);
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_parity();
    test_bad_stop();
    test_break();
    test_glitch();
    test_overrun();
    test_reset_mid();
    test_enable();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
